// File: rtl/key_event_arbiter.sv
// Push-button front end: synchronizes and debounces N raw keys and queues press events in a small FIFO.
// Optional macro KEY_RELEASE_EVT_EN also queues release events and adds the evt_release output.
module key_event_arbiter #(
  parameter int N_KEYS     = 4,
  parameter int CODE_W     = 2,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] key_state,
  output logic              overflow
`ifdef KEY_RELEASE_EVT_EN
  ,
  output logic              evt_release
`endif
);

`ifdef KEY_RELEASE_EVT_EN
  localparam int REQ_N   = 2 * N_KEYS;
  localparam int ENTRY_W = CODE_W + 1;
`else
  localparam int REQ_N   = N_KEYS;
  localparam int ENTRY_W = CODE_W;
`endif
  localparam int RR_W  = $clog2(REQ_N);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_KEYS-1:0]     sync1;
  logic [N_KEYS-1:0]     sync2;
  logic [CNT_W-1:0]      presc;
  logic                  tick;
  logic [STABLE_CNT-1:0] hist      [N_KEYS];
  logic [STABLE_CNT-1:0] hist_next [N_KEYS];
  logic [N_KEYS-1:0]     rise;
  logic [N_KEYS-1:0]     fall;
  logic [N_KEYS-1:0]     press_pend;
`ifdef KEY_RELEASE_EVT_EN
  logic [N_KEYS-1:0]     rel_pend;
`endif
  logic [REQ_N-1:0]      req;
  logic [REQ_N-1:0]      grant_oh;
  logic [RR_W-1:0]       rr_ptr;
  logic [RR_W-1:0]       grant_idx;
  logic [RR_W-1:0]       idx;
  logic                  grant_found;
  logic                  push;
  logic                  pop;
  logic                  lost;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  // Two-flop synchronizer; only sync2 is ever looked at by the debouncer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign tick = (presc == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A level change needs STABLE_CNT identical samples, counting the one taken this tick.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      hist_next[i] = {hist[i][STABLE_CNT-2:0], sync2[i]};
      rise[i]      = tick && (&hist_next[i]) && !key_state[i];
      fall[i]      = tick && !(|hist_next[i]) && key_state[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        hist[i] <= '0;
      end
      key_state <= '0;
    end else begin
      if (tick) begin
        for (int i = 0; i < N_KEYS; i++) begin
          hist[i] <= hist_next[i];
        end
      end
      key_state <= (key_state | rise) & ~fall;
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  assign req  = {rel_pend, press_pend};
  assign lost = (|(press_pend & rise)) | (|(rel_pend & fall));
`else
  assign req  = press_pend;
  assign lost = |(press_pend & rise);
`endif

  // Round-robin search starting at rr_ptr, wrapping at REQ_N.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < REQ_N; k++) begin
      idx = RR_W'((int'(rr_ptr) + k) % REQ_N);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign push     = grant_found && (count < (PTR_W + 1)'(FIFO_DEPTH));
  assign pop      = evt_valid && evt_ready;
  assign grant_oh = push ? (REQ_N'(1) << grant_idx) : '0;

  always_comb begin
`ifdef KEY_RELEASE_EVT_EN
    if (grant_idx >= RR_W'(N_KEYS)) begin
      push_entry = {1'b1, CODE_W'(grant_idx - RR_W'(N_KEYS))};
    end else begin
      push_entry = {1'b0, CODE_W'(grant_idx)};
    end
`else
    push_entry = CODE_W'(grant_idx);
`endif
  end

  // A new edge is OR-ed in after the grant clear, so a same-cycle set always survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pend <= '0;
`ifdef KEY_RELEASE_EVT_EN
      rel_pend   <= '0;
`endif
      rr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~grant_oh[N_KEYS-1:0]) | rise;
`ifdef KEY_RELEASE_EVT_EN
      rel_pend   <= (rel_pend & ~grant_oh[REQ_N-1:N_KEYS]) | fall;
`endif
      overflow   <= overflow | lost;
      if (push) begin
        rr_ptr <= (grant_idx == RR_W'(REQ_N - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_code  = head[CODE_W-1:0];
`ifdef KEY_RELEASE_EVT_EN
  assign evt_release = head[CODE_W];
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized scoreboard bench for key_event_arbiter; a queue-based reference model predicts events.
module tb_key_event_arbiter;

  localparam int N  = 8;
  localparam int CW = 3;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  key_in = '0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [CW-1:0] evt_code;
  logic [N-1:0]  key_state;
  logic          overflow;

  key_event_arbiter #(
    .N_KEYS(N), .CODE_W(CW), .TICK_DIV(TD), .STABLE_CNT(SC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .key_state(key_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int events_seen = 0;
  bit checks_on = 1'b0;

  // Reference model: plain arrays and queues driven by the behavioural rules.
  bit [N-1:0] m_s1, m_s2, m_ks, m_pend;
  int         m_cnt;
  int         m_rr;
  int         m_samp [N][SC];
  int         m_fifo [$];
  bit         m_ovf;
  int         exp_q  [$];

  task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit         tick;
    int         g;
    bit [N-1:0] pend_old;
    bit         same;
    int         v;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_ks = '0; m_pend = '0;
      m_cnt = 0; m_rr = 0; m_ovf = 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < SC; j++) m_samp[i][j] = 0;
      m_fifo.delete();
      exp_q.delete();
      checks_on = 1'b1;
      return;
    end
    pend_old = m_pend;
    tick  = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    g = -1;
    if (m_pend != 0 && m_fifo.size() < FD)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    if (m_fifo.size() != 0 && evt_ready) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(g);
      exp_q.push_back(g);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < SC - 1; j++) m_samp[i][j] = m_samp[i][j+1];
        m_samp[i][SC-1] = int'(m_s2[i]);
        v = m_samp[i][0];
        same = 1'b1;
        for (int j = 1; j < SC; j++) if (m_samp[i][j] != v) same = 1'b0;
        if (same && v != int'(m_ks[i])) begin
          m_ks[i] = (v != 0);
          if (v != 0) begin
            if (pend_old[i]) m_ovf = 1'b1;
            m_pend[i] = 1'b1;
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = key_in;
  endtask

  task automatic checkOutput();
    if (!checks_on) return;
    compareValue("evt_valid", 32'(evt_valid), 32'(m_fifo.size() != 0));
    compareValue("key_state", 32'(key_state), 32'(m_ks));
    compareValue("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic applyStimulus(input bit r, input bit [N-1:0] k, input bit rdy);
    @(negedge clk);
    checkOutput();
    #1;
    rst = r;
    key_in = k;
    evt_ready = rdy;
    @(posedge clk);
    model_step();
  endtask

  // Monitor: pops the scoreboard on every DUT handshake, and checks hold-stability under backpressure.
  initial begin
    int         e;
    bit         prev_stall = 1'b0;
    logic [CW-1:0] prev_code = '0;
    forever begin
      @(negedge clk);
      #2;
      if (checks_on && !rst) begin
        if (prev_stall) begin
          compareValue("stall_valid", 32'(evt_valid), 32'd1);
          compareValue("stall_code",  32'(evt_code),  32'(prev_code));
        end
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            compareValue("evt_unexpected", 32'(evt_code), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            compareValue("evt_code", 32'(evt_code), 32'(e));
            events_seen++;
          end
        end
        prev_stall = evt_valid && !evt_ready;
        prev_code  = evt_code;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit [N-1:0] k;
    int         bias;
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, '0, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, '0, 1'b0);

    // Single press on key 2, held under backpressure, then drained.
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, 8'h04, 1'b0);
    for (int c = 0; c < 5; c++)  applyStimulus(1'b0, 8'h04, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Bouncing key 0.
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, N'((c / 3) % 2), 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, '0, 1'b1);

    // Simultaneous presses on keys 1 and 3.
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, 8'h0A, 1'b0);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 8'h0A, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Five presses into a four-entry FIFO, then a re-press of the still-pending key.
    for (int c = 0; c < 30; c++) applyStimulus(1'b0, 8'h75, 1'b0);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 8'h75, 1'b0);
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Mid-operation reset with events queued and keys still held.
    applyStimulus(1'b1, '0, 1'b0);
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 8'h06, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0);
    for (int c = 0; c < 25; c++) applyStimulus(1'b0, 8'h06, 1'b1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Randomized traffic with shifting consumer bias and rare resets.
    k = '0;
    bias = 5;
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) bias = $urandom_range(0, 10);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 19) == 0) k[b] = ~k[b];
      applyStimulus($urandom_range(0, 699) == 0, k, $urandom_range(0, 9) < bias);
    end

    for (int c = 0; c < 60; c++) applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput();
    compareValue("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    compareValue("events_seen_nonzero", 32'(events_seen > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
